// File: rtl/trap_arbiter.sv
// trap_arbiter: serialises synchronous exceptions, ctx/heap unit exceptions and
// level IRQs into single trap-taken strobes, flushing the pipeline first.
// Optional heap source: define TRAP_ARBITER_HEAP_EN to enable it.
// take_* outputs are registered: the strobe appears in the cycle after ISSUE.
module trap_arbiter #(
  parameter int unsigned DRAIN_MAX      = 15,
  parameter int unsigned HOLDOFF_CYCLES = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        exc_valid_i,
  input  logic [31:0] exc_cause_i,
  input  logic        ctx_valid_i,
  input  logic [2:0]  ctx_code_i,
  input  logic        heap_valid_i,
  input  logic [2:0]  heap_code_i,
  input  logic [2:0]  irq_i,
  input  logic        irq_en_i,
  input  logic        mret_i,
  input  logic        drain_done_i,
  output logic        flush_o,
  output logic        take_valid_o,
  output logic [1:0]  take_class_o,
  output logic [31:0] take_cause_o,
  output logic        busy_o
);

  localparam int unsigned DCW = 8;
  localparam int unsigned HCW = 16;

  localparam logic [1:0]  CLS_EXC  = 2'd0;
  localparam logic [1:0]  CLS_CTX  = 2'd1;
  localparam logic [1:0]  CLS_HEAP = 2'd2;
  localparam logic [1:0]  CLS_IRQ  = 2'd3;

  localparam logic [31:0] CAUSE_EXT   = {1'b1, 27'd0, 4'd11};
  localparam logic [31:0] CAUSE_TIMER = {1'b1, 27'd0, 4'd7};
  localparam logic [31:0] CAUSE_SW    = {1'b1, 27'd0, 4'd3};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    ISSUE = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [DCW-1:0]   drain_cnt_q, drain_cnt_d;
  logic [HCW-1:0]   hold_cnt_q, hold_cnt_d;

  logic             ctx_pend_q;
  logic [2:0]       ctx_code_q;
  logic             ctx_set, ctx_clr;
  logic             heap_pend_q;
  logic [2:0]       heap_code_q;
  logic             heap_clr;

  logic             irq_ok, hi_elig, any_elig;
  logic             win_valid;
  logic [1:0]       win_class;
  logic [31:0]      win_cause;
  logic             take_d;

  logic             flush_q, busy_q, take_valid_q;
  logic [1:0]       take_class_q;
  logic [31:0]      take_cause_q;

  // IRQs are masked globally and during the post-issue holdoff window
  assign irq_ok   = irq_en_i && (|irq_i) && (state_q != HOLD);
  assign hi_elig  = exc_valid_i || ctx_pend_q || heap_pend_q;
  assign any_elig = hi_elig || irq_ok;

  // Fixed-priority winner: exc > ctx > heap > ext > timer > sw
  always_comb begin
    win_valid = 1'b1;
    win_class = CLS_EXC;
    win_cause = '0;
    if (exc_valid_i) begin
      win_class = CLS_EXC;
      win_cause = exc_cause_i;
    end else if (ctx_pend_q) begin
      win_class = CLS_CTX;
      win_cause = {29'd0, ctx_code_q};
    end else if (heap_pend_q) begin
      win_class = CLS_HEAP;
      win_cause = {29'd0, heap_code_q};
    end else if (irq_ok && irq_i[2]) begin
      win_class = CLS_IRQ;
      win_cause = CAUSE_EXT;
    end else if (irq_ok && irq_i[1]) begin
      win_class = CLS_IRQ;
      win_cause = CAUSE_TIMER;
    end else if (irq_ok && irq_i[0]) begin
      win_class = CLS_IRQ;
      win_cause = CAUSE_SW;
    end else begin
      win_valid = 1'b0;
    end
  end

  // Next-state, counters and issue decision
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    take_d      = 1'b0;
    ctx_clr     = 1'b0;
    heap_clr    = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_elig) begin
          state_d     = DRAIN;
          drain_cnt_d = DCW'(1);
        end
      end
      DRAIN: begin
        if (!any_elig) begin
          state_d = IDLE;
        end else if (drain_done_i || (drain_cnt_q >= DCW'(DRAIN_MAX))) begin
          state_d = ISSUE;
        end else if (drain_cnt_q != {DCW{1'b1}}) begin
          drain_cnt_d = drain_cnt_q + DCW'(1);
        end
      end
      ISSUE: begin
        if (win_valid) begin
          take_d   = 1'b1;
          ctx_clr  = (win_class == CLS_CTX);
          heap_clr = (win_class == CLS_HEAP);
          if (HOLDOFF_CYCLES > 0) begin
            state_d    = HOLD;
            hold_cnt_d = HCW'(HOLDOFF_CYCLES);
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (hi_elig) begin
          state_d     = DRAIN;
          drain_cnt_d = DCW'(1);
        end else if ((hold_cnt_q <= HCW'(1)) || mret_i) begin
          state_d = IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q - HCW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      drain_cnt_q <= '0;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  // Registered outputs; class/cause forced to zero outside the strobe
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flush_q      <= 1'b0;
      busy_q       <= 1'b0;
      take_valid_q <= 1'b0;
      take_class_q <= 2'd0;
      take_cause_q <= 32'd0;
    end else begin
      flush_q      <= (state_d == DRAIN);
      busy_q       <= (state_d != IDLE);
      take_valid_q <= take_d;
      take_class_q <= take_d ? win_class : 2'd0;
      take_cause_q <= take_d ? win_cause : 32'd0;
    end
  end

  // Sticky ctx pending; a new pulse is accepted in the cycle the old one clears
  assign ctx_set = ctx_valid_i && (ctx_code_i >= 3'd2) && (!ctx_pend_q || ctx_clr);

  // ctx pending bit and captured code
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctx_pend_q <= 1'b0;
      ctx_code_q <= 3'd0;
    end else if (ctx_set) begin
      ctx_pend_q <= 1'b1;
      ctx_code_q <= ctx_code_i;
    end else if (ctx_clr) begin
      ctx_pend_q <= 1'b0;
    end
  end

`ifdef TRAP_ARBITER_HEAP_EN
  logic heap_set;

  assign heap_set = heap_valid_i && ((heap_code_i == 3'd6) || (heap_code_i == 3'd7)) &&
                    (!heap_pend_q || heap_clr);

  // heap pending bit and captured code
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      heap_pend_q <= 1'b0;
      heap_code_q <= 3'd0;
    end else if (heap_set) begin
      heap_pend_q <= 1'b1;
      heap_code_q <= heap_code_i;
    end else if (heap_clr) begin
      heap_pend_q <= 1'b0;
    end
  end
`else
  logic unused_heap;

  // Heap source absent: inputs are sunk, pending never set
  assign heap_pend_q = 1'b0;
  assign heap_code_q = 3'd0;
  assign unused_heap = heap_valid_i ^ (^heap_code_i) ^ heap_clr;
`endif

  assign flush_o      = flush_q;
  assign busy_o       = busy_q;
  assign take_valid_o = take_valid_q;
  assign take_class_o = take_class_q;
  assign take_cause_o = take_cause_q;

endmodule

// File: tb/tb_trap_arbiter.sv
// Bench for trap_arbiter: directed scenarios then random traffic, all checked
// cycle by cycle against a timestamp-based behavioural model.
module tb_trap_arbiter;

  localparam int unsigned DRAIN_MAX = 15;
  localparam int unsigned HOLDOFF   = 4;

  localparam int P_IDLE  = 0;
  localparam int P_DRAIN = 1;
  localparam int P_ISSUE = 2;
  localparam int P_HOLD  = 3;

  logic        clk_i        = 1'b0;
  logic        rst_ni       = 1'b0;
  logic        exc_valid_i  = 1'b0;
  logic [31:0] exc_cause_i  = 32'd0;
  logic        ctx_valid_i  = 1'b0;
  logic [2:0]  ctx_code_i   = 3'd0;
  logic        heap_valid_i = 1'b0;
  logic [2:0]  heap_code_i  = 3'd0;
  logic [2:0]  irq_i        = 3'd0;
  logic        irq_en_i     = 1'b0;
  logic        mret_i       = 1'b0;
  logic        drain_done_i = 1'b0;
  logic        flush_o;
  logic        take_valid_o;
  logic [1:0]  take_class_o;
  logic [31:0] take_cause_o;
  logic        busy_o;

  trap_arbiter #(.DRAIN_MAX(DRAIN_MAX), .HOLDOFF_CYCLES(HOLDOFF)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .exc_valid_i  (exc_valid_i),
    .exc_cause_i  (exc_cause_i),
    .ctx_valid_i  (ctx_valid_i),
    .ctx_code_i   (ctx_code_i),
    .heap_valid_i (heap_valid_i),
    .heap_code_i  (heap_code_i),
    .irq_i        (irq_i),
    .irq_en_i     (irq_en_i),
    .mret_i       (mret_i),
    .drain_done_i (drain_done_i),
    .flush_o      (flush_o),
    .take_valid_o (take_valid_o),
    .take_class_o (take_class_o),
    .take_cause_o (take_cause_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // model: phase plus absolute-cycle timestamps; pending sources as code or -1
  int          m_phase = P_IDLE;
  int          m_cyc   = 0;
  int          m_t0    = 0;
  int          m_hold_end = 0;
  int          m_ctx   = -1;
  int          m_heap  = -1;
  logic        e_flush = 1'b0;
  logic        e_busy  = 1'b0;
  logic        e_take  = 1'b0;
  logic [1:0]  e_cls   = 2'd0;
  logic [31:0] e_cause = 32'd0;

  // observations of the DUT, compared against constants by directed steps
  int          cyc = 0;
  int          flush_cnt = 0;
  int          busy_cnt  = 0;
  logic [1:0]  tk_cls[$];
  logic [31:0] tk_cause[$];
  int          tk_cyc[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = P_IDLE;
    m_ctx   = -1;
    m_heap  = -1;
    e_flush = 1'b0;
    e_busy  = 1'b0;
    e_take  = 1'b0;
    e_cls   = 2'd0;
    e_cause = 32'd0;
  endtask

  task automatic model_step();
    int          nph;
    bit          irq_ok, hi, clr_c, clr_h;
    int          ccls[$];
    logic [31:0] ccause[$];
    nph   = m_phase;
    clr_c = 1'b0;
    clr_h = 1'b0;
    irq_ok = irq_en_i && (irq_i != 3'd0) && (m_phase != P_HOLD);
    hi     = exc_valid_i || (m_ctx >= 0) || (m_heap >= 0);
    e_take  = 1'b0;
    e_cls   = 2'd0;
    e_cause = 32'd0;
    case (m_phase)
      P_IDLE: begin
        if (hi || irq_ok) begin
          nph  = P_DRAIN;
          m_t0 = m_cyc + 1;
        end
      end
      P_DRAIN: begin
        if (!(hi || irq_ok)) nph = P_IDLE;
        else if (drain_done_i || (m_cyc - m_t0 + 1 >= int'(DRAIN_MAX))) nph = P_ISSUE;
      end
      P_ISSUE: begin
        if (exc_valid_i) begin ccls.push_back(0); ccause.push_back(exc_cause_i); end
        if (m_ctx >= 0) begin ccls.push_back(1); ccause.push_back(32'(m_ctx)); end
        if (m_heap >= 0) begin ccls.push_back(2); ccause.push_back(32'(m_heap)); end
        if (irq_en_i) begin
          for (int b = 2; b >= 0; b--) begin
            if (irq_i[b]) begin
              ccls.push_back(3);
              ccause.push_back(32'h8000_0000 | 32'(4 * b + 3));
            end
          end
        end
        if (ccls.size() > 0) begin
          e_take  = 1'b1;
          e_cls   = 2'(ccls[0]);
          e_cause = ccause[0];
          clr_c   = (ccls[0] == 1);
          clr_h   = (ccls[0] == 2);
          if (HOLDOFF > 0) begin
            nph        = P_HOLD;
            m_hold_end = m_cyc + int'(HOLDOFF);
          end else begin
            nph = P_IDLE;
          end
        end else begin
          nph = P_IDLE;
        end
      end
      default: begin
        if (hi) begin
          nph  = P_DRAIN;
          m_t0 = m_cyc + 1;
        end else if ((m_cyc >= m_hold_end) || mret_i) begin
          nph = P_IDLE;
        end
      end
    endcase
    if (ctx_valid_i && (ctx_code_i >= 3'd2) && ((m_ctx < 0) || clr_c)) m_ctx = int'(ctx_code_i);
    else if (clr_c) m_ctx = -1;
`ifdef TRAP_ARBITER_HEAP_EN
    if (heap_valid_i && (heap_code_i >= 3'd6) && ((m_heap < 0) || clr_h)) m_heap = int'(heap_code_i);
    else if (clr_h) m_heap = -1;
`else
    if (clr_h) m_heap = -1;
`endif
    m_phase = nph;
    e_flush = (nph == P_DRAIN);
    e_busy  = (nph != P_IDLE);
    m_cyc++;
  endtask

  // one clock: advance model with the driven inputs, then compare at negedge
  task automatic tick();
    if (!rst_ni) model_reset();
    else model_step();
    @(posedge clk_i);
    @(negedge clk_i);
    cyc++;
    chk("flush", 32'(flush_o), 32'(e_flush));
    chk("busy", 32'(busy_o), 32'(e_busy));
    chk("take_valid", 32'(take_valid_o), 32'(e_take));
    chk("take_class", 32'(take_class_o), 32'(e_cls));
    chk("take_cause", take_cause_o, e_cause);
    if (take_valid_o === 1'b1) begin
      tk_cls.push_back(take_class_o);
      tk_cause.push_back(take_cause_o);
      tk_cyc.push_back(cyc);
    end
    if (flush_o === 1'b1) flush_cnt++;
    if (busy_o === 1'b1) busy_cnt++;
  endtask

  task automatic clear_obs();
    tk_cls.delete();
    tk_cause.delete();
    tk_cyc.delete();
    flush_cnt = 0;
    busy_cnt  = 0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk_i);
    chk("rst_flush", 32'(flush_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_take", 32'(take_valid_o), 32'd0);
    chk("rst_class", 32'(take_class_o), 32'd0);
    chk("rst_cause", take_cause_o, 32'd0);
    rst_ni = 1'b1;
    repeat (2) tick();

    // exception with pipeline drained after three flush cycles
    clear_obs();
    exc_valid_i = 1'b1;
    exc_cause_i = 32'd2;
    repeat (3) tick();
    drain_done_i = 1'b1;
    tick();
    drain_done_i = 1'b0;
    tick();
    exc_valid_i = 1'b0;
    repeat (8) tick();
    chk("exc_flush_cycles", 32'(flush_cnt), 32'd3);
    chk("exc_take_count", 32'(tk_cls.size()), 32'd1);
    if (tk_cls.size() >= 1) begin
      chk("exc_class", 32'(tk_cls[0]), 32'd0);
      chk("exc_cause", tk_cause[0], 32'd2);
    end

    // ctx beats timer; timer only after holdoff expires
    clear_obs();
    ctx_valid_i  = 1'b1;
    ctx_code_i   = 3'd3;
    irq_i        = 3'b010;
    irq_en_i     = 1'b1;
    drain_done_i = 1'b1;
    tick();
    ctx_valid_i = 1'b0;
    for (int i = 0; i < 30 && tk_cls.size() < 2; i++) tick();
    irq_i        = 3'b000;
    drain_done_i = 1'b0;
    repeat (8) tick();
    irq_en_i = 1'b0;
    chk("prio_take_count", 32'(tk_cls.size()), 32'd2);
    if (tk_cls.size() >= 2) begin
      chk("prio_first_class", 32'(tk_cls[0]), 32'd1);
      chk("prio_first_cause", tk_cause[0], 32'd3);
      chk("prio_second_class", 32'(tk_cls[1]), 32'd3);
      chk("prio_second_cause", tk_cause[1], 32'h8000_0007);
      chk("prio_gap", 32'(tk_cyc[1] - tk_cyc[0]), 32'(HOLDOFF + 3));
    end

    // drain timeout with drain_done never asserted
    clear_obs();
    exc_valid_i = 1'b1;
    exc_cause_i = 32'd5;
    tick();
    for (int i = 0; i < 40 && flush_o === 1'b1; i++) tick();
    tick();
    exc_valid_i = 1'b0;
    repeat (8) tick();
    chk("timeout_flush_cycles", 32'(flush_cnt), 32'(DRAIN_MAX));
    chk("timeout_take_count", 32'(tk_cls.size()), 32'd1);
    if (tk_cls.size() >= 1) chk("timeout_cause", tk_cause[0], 32'd5);

    // irq withdrawn during drain returns to idle silently
    clear_obs();
    irq_i    = 3'b001;
    irq_en_i = 1'b1;
    repeat (2) tick();
    irq_i = 3'b000;
    tick();
    chk("withdraw_flush", 32'(flush_o), 32'd0);
    chk("withdraw_busy", 32'(busy_o), 32'd0);
    repeat (3) tick();
    chk("withdraw_takes", 32'(tk_cls.size()), 32'd0);
    irq_en_i = 1'b0;

    // heap-full pulse
    clear_obs();
    heap_valid_i = 1'b1;
    heap_code_i  = 3'd6;
    drain_done_i = 1'b1;
    tick();
    heap_valid_i = 1'b0;
    repeat (10) tick();
    drain_done_i = 1'b0;
`ifdef TRAP_ARBITER_HEAP_EN
    chk("heap_take_count", 32'(tk_cls.size()), 32'd1);
    if (tk_cls.size() >= 1) begin
      chk("heap_class", 32'(tk_cls[0]), 32'd2);
      chk("heap_cause", tk_cause[0], 32'd6);
    end
`else
    chk("heap_take_count", 32'(tk_cls.size()), 32'd0);
    chk("heap_busy_cycles", 32'(busy_cnt), 32'd0);
`endif

    // reset asserted in the middle of a drain
    clear_obs();
    exc_valid_i = 1'b1;
    exc_cause_i = 32'd9;
    ctx_valid_i = 1'b1;
    ctx_code_i  = 3'd4;
    tick();
    ctx_valid_i = 1'b0;
    tick();
    chk("mid_drain_flush", 32'(flush_o), 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    chk("async_rst_flush", 32'(flush_o), 32'd0);
    chk("async_rst_busy", 32'(busy_o), 32'd0);
    chk("async_rst_take", 32'(take_valid_o), 32'd0);
    model_reset();
    exc_valid_i = 1'b0;
    repeat (2) tick();
    rst_ni = 1'b1;
    repeat (4) tick();
    chk("post_rst_busy", 32'(busy_o), 32'd0);
    chk("post_rst_takes", 32'(tk_cls.size()), 32'd0);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if (exc_valid_i && e_take && (e_cls == 2'd0)) begin
        exc_valid_i = 1'b0;
      end else if (!exc_valid_i && ($urandom_range(0, 19) == 0)) begin
        exc_valid_i = 1'b1;
        exc_cause_i = $urandom;
      end
      ctx_valid_i  = ($urandom_range(0, 9) == 0);
      ctx_code_i   = 3'($urandom_range(0, 7));
      heap_valid_i = ($urandom_range(0, 9) == 0);
      heap_code_i  = 3'($urandom_range(4, 7));
      if ($urandom_range(0, 7) == 0) irq_i = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) irq_en_i = ~irq_en_i;
      mret_i       = ($urandom_range(0, 7) == 0);
      drain_done_i = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
